sram6116_arb: RTL and testbench
===============================

SRAM6116_ARB -- requirements
Module: sram6116_arb

Interface
REQ-001: Parameter ADDR_W SHALL be present: default 11; SRAM address width (2K x 8 part).
REQ-002: Parameter DATA_W SHALL be present: default 8; SRAM data width.
REQ-003: Port phi0 SHALL be: input, 1, system clock; all state updates on rising edge.
REQ-004: Port rst_b SHALL be: input, 1, asynchronous active-low reset.
REQ-005: Port cpu_req SHALL be: input, 1, CPU access request; level, held until cpu_ack.
REQ-006: Port cpu_we SHALL be: input, 1, CPU op select; 1 = write, 0 = read.
REQ-007: Ports cpu_addr and cpu_wdata SHALL be: input, ADDR_W and DATA_W; CPU address and write data.
REQ-008: Port cpu_ack SHALL be: output, 1, one-cycle completion pulse for CPU.
REQ-009: Port cpu_rdata SHALL be: output, DATA_W, CPU read data; valid while cpu_ack=1 after a read.
REQ-010: Ports vid_req, vid_we, vid_addr, vid_wdata, vid_ack and vid_rdata SHALL behave identically to the cpu_* ports, for the video/DMA requester.
REQ-011: Ports sram_A, sram_Din, sram_CS_b, sram_WE_b and sram_OE_b SHALL be: output, ADDR_W/DATA_W/1/1/1; drive the 6116 controller, strobes active-low.
REQ-012: Port sram_Dout SHALL be: input, DATA_W; registered SRAM read data; may be Z outside reads.
REQ-013: Port busy SHALL be: output, 1; high whenever state is not IDLE.

Function
REQ-014: FSM states SHALL be IDLE, STROBE and CAPTURE; each state lasts exactly one phi0 cycle except IDLE.
REQ-015: All sram_* outputs, acks and rdata SHALL be registered; there SHALL be no combinational path from any *_req to any sram_* output.
REQ-016: At an IDLE edge with at least one eligible request, the arbiter SHALL latch the winner's addr, wdata and we onto sram_A/sram_Din, drive CS_b=0, WE_b=~we and OE_b=we, and go to STROBE.
REQ-017: A port SHALL be eligible only if its req=1 and its ack is not high in that same cycle, which prevents re-servicing a request being dropped.
REQ-018: Arbitration SHALL be round-robin: if both ports are eligible, the port not granted last wins; a single eligible port always wins; last_grant updates only on grant.
REQ-019: At the STROBE exit edge, the strobes SHALL return to CS_b=1, WE_b=1, OE_b=1.
REQ-020: For a write, the STROBE exit edge SHALL pulse ack of the granted port and return the FSM to IDLE.
REQ-021: For a read, the STROBE exit edge SHALL move the FSM to CAPTURE.
REQ-022: At the CAPTURE exit edge, the arbiter SHALL load sram_Dout into the granted port's rdata, pulse that port's ack, and return to IDLE.
REQ-023: Latency from the req-sampling edge to ack high SHALL be 1 cycle for writes and 2 cycles for reads.
REQ-024: Throughput SHALL be one write every 2 cycles and one read every 3 cycles; a new grant MAY occur on the edge ending the ack cycle.
REQ-025: rdata of a port SHALL hold its last captured value until that port's next read completes; writes SHALL NOT alter rdata.
REQ-026: sram_A and sram_Din SHALL hold their values outside STROBE; only strobes signal validity.
REQ-027: A req deasserted before ack (a protocol violation) SHALL NOT abort an access in flight; the ack SHALL still pulse.
REQ-028: The two acks SHALL never be high in the same cycle.

Reset
REQ-029: While rst_b=0, the block SHALL asynchronously force: state=IDLE, sram_CS_b=1, sram_WE_b=1, sram_OE_b=1, sram_A=0, sram_Din=0, cpu_ack=0, vid_ack=0, cpu_rdata=0, vid_rdata=0, busy=0, last_grant=vid.
REQ-030: A reset during STROBE or CAPTURE SHALL abandon the access with no ack; the requester SHALL re-issue it.
REQ-031: The first tie after reset SHALL be won by the CPU.

Verification
REQ-032: Scenario CPU write: CPU write addr 0x123, data 0xA5 -> one STROBE cycle with CS_b=0, WE_b=0, OE_b=1, A=0x123; cpu_ack high 1 cycle after sampling.
REQ-033: Scenario CPU readback: CPU read of 0x123 after that write -> OE_b=0 for one cycle; cpu_ack 2 cycles after sampling with cpu_rdata=0xA5.
REQ-034: Scenario tie: cpu_req and vid_req both high from reset, both reads, held until ack -> grant order CPU, vid, CPU, vid...; acks never overlap.
REQ-035: Scenario data isolation: vid writes 0x7FF=0x3C while the CPU repeatedly reads 0x000=0x11 -> vid_ack within 3 cycles of request; cpu_rdata stays 0x11.
REQ-036: Scenario reset mid-read: rst_b low during CAPTURE -> all strobes high immediately, no ack, busy=0; the next request completes normally.
REQ-037: Scenario back-to-back: CPU issues 4 writes to 0x000..0x003 with req re-raised on the cycle after ack -> exactly 4 acks, no duplicate STROBE per request.

Source files
------------

// File: rtl/sram6116_arb_if.sv
// Bus bundle between the two requesters (CPU, video/DMA), the 6116 SRAM controller
// pins and the sram6116_arb arbiter.
interface sram6116_arb_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    // Requester handshake: req is a level held until ack; ack is a one-cycle pulse that
    // completes the access; rdata is valid while ack is high after a read and holds afterwards.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vid_req;
    logic              vid_we;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_wdata;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;

    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_Din;
    logic              sram_CS_b;
    logic              sram_WE_b;
    logic              sram_OE_b;
    logic [DATA_W-1:0] sram_Dout;

    logic              busy;

    // Requesters plus the SRAM device side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output vid_req, vid_we, vid_addr, vid_wdata,
        input  vid_ack, vid_rdata,
        input  sram_A, sram_Din, sram_CS_b, sram_WE_b, sram_OE_b,
        output sram_Dout,
        input  busy
    );

    // The arbiter.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  vid_req, vid_we, vid_addr, vid_wdata,
        output vid_ack, vid_rdata,
        output sram_A, sram_Din, sram_CS_b, sram_WE_b, sram_OE_b,
        input  sram_Dout,
        output busy
    );
endinterface

// File: rtl/sram6116_arb.sv
// Two-port round-robin arbiter in front of a 2K x 8 6116 SRAM controller.
// Writes take IDLE->STROBE, reads IDLE->STROBE->CAPTURE; every pin is driven from a flop.
module sram6116_arb #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic       phi0,
    input  logic       rst_b,
    sram6116_arb_if.slave bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } grant_t;

    state_t            state_q;
    grant_t            grant_q;
    grant_t            last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] din_q;
    logic              cs_b_q;
    logic              we_b_q;
    logic              oe_b_q;
    logic              cpu_ack_q;
    logic              vid_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    logic              cpu_elig;
    logic              vid_elig;
    logic              any_elig;
    grant_t            grant_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // A port in its ack cycle is ignored so a request being dropped is not serviced twice.
    assign cpu_elig = bus.cpu_req & ~cpu_ack_q;
    assign vid_elig = bus.vid_req & ~vid_ack_q;
    assign any_elig = cpu_elig | vid_elig;

    always_comb begin
        grant_d = GNT_CPU;
        if (cpu_elig && vid_elig) begin
            grant_d = (last_grant_q == GNT_VID) ? GNT_CPU : GNT_VID;
        end else if (vid_elig) begin
            grant_d = GNT_VID;
        end
    end

    always_comb begin
        we_d    = bus.cpu_we;
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        if (grant_d == GNT_VID) begin
            we_d    = bus.vid_we;
            addr_d  = bus.vid_addr;
            wdata_d = bus.vid_wdata;
        end
    end

    always_ff @(posedge phi0 or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_VID;
            we_q         <= 1'b0;
            a_q          <= '0;
            din_q        <= '0;
            cs_b_q       <= 1'b1;
            we_b_q       <= 1'b1;
            oe_b_q       <= 1'b1;
            cpu_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            vid_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= we_d;
                        a_q          <= addr_d;
                        din_q        <= wdata_d;
                        cs_b_q       <= 1'b0;
                        we_b_q       <= ~we_d;
                        oe_b_q       <= we_d;
                        state_q      <= STROBE;
                    end
                end
                STROBE: begin
                    // Address and data stay put; only the strobes mark the access window.
                    cs_b_q <= 1'b1;
                    we_b_q <= 1'b1;
                    oe_b_q <= 1'b1;
                    if (we_q) begin
                        if (grant_q == GNT_CPU) cpu_ack_q <= 1'b1;
                        else                    vid_ack_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (grant_q == GNT_CPU) begin
                        cpu_rdata_q <= bus.sram_Dout;
                        cpu_ack_q   <= 1'b1;
                    end else begin
                        vid_rdata_q <= bus.sram_Dout;
                        vid_ack_q   <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_A    = a_q;
    assign bus.sram_Din  = din_q;
    assign bus.sram_CS_b = cs_b_q;
    assign bus.sram_WE_b = we_b_q;
    assign bus.sram_OE_b = oe_b_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.vid_ack   = vid_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram6116_arb.sv
// Directed bench for sram6116_arb: behavioural 6116 model, vector table of single accesses,
// and hand-written sequences for pin timing, ties, isolation, mid-read reset and back-to-back.
module tb_sram6116_arb;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic       phi0 = 1'b0;
  logic       rst_b = 1'b0;
  logic [1:0] dbg_state;

  sram6116_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram6116_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .phi0       (phi0),
    .rst_b      (rst_b),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 phi0 = ~phi0;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- 6116 model (registered read data) ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge phi0) begin
    if (!bus.sram_CS_b && !bus.sram_WE_b) mem[bus.sram_A] <= bus.sram_Din;
    if (!bus.sram_CS_b && !bus.sram_OE_b) bus.sram_Dout <= mem[bus.sram_A];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int strobe_cnt = 0;
  int ack_cnt = 0;

  always @(negedge phi0) begin
    if (rst_b) begin
      if (!bus.sram_CS_b) strobe_cnt++;
      if (bus.cpu_ack || bus.vid_ack) ack_cnt++;
      check("ack_overlap", {31'b0, bus.cpu_ack & bus.vid_ack}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Raises req at the next negedge, waits (bounded) for ack, checks latency and rdata, drops req.
  task automatic do_access(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int exp_lat, input bit lat_max,
                           input logic [DATA_W-1:0] exp_rdata, input string name);
    int  n;
    bit  seen;
    @(negedge phi0);
    if (!port) begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end else begin
      bus.vid_we = we; bus.vid_addr = addr; bus.vid_wdata = wdata; bus.vid_req = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge phi0);
      n++;
      seen = port ? bus.vid_ack : bus.cpu_ack;
    end
    check({name, "_ack"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      if (lat_max) check({name, "_lat_max"}, {31'b0, (n - 1) <= exp_lat}, 32'd1);
      else         check({name, "_lat"}, n - 1, exp_lat);
      check({name, "_rdata"}, port ? bus.vid_rdata : bus.cpu_rdata, {24'b0, exp_rdata});
    end
    if (!port) bus.cpu_req = 1'b0;
    else       bus.vid_req = 1'b0;
  endtask

  typedef struct {
    bit                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                lat;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  vec_t vecs[9];

  // ---------------- test ----------------
  initial begin
    int got;
    int s0;
    int a0;
    int iso_acks;
    logic [8:0] e;

    // port, we, addr, wdata, latency, rdata of that port at ack
    vecs[0] = '{1'b0, 1'b1, 11'h000, 8'h11, 1, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 11'h7FF, 8'h3C, 1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 11'h7FF, 8'h00, 2, 8'h3C};
    vecs[3] = '{1'b0, 1'b0, 11'h000, 8'h00, 2, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 11'h555, 8'h5A, 1, 8'h11};
    vecs[5] = '{1'b1, 1'b1, 11'h2AA, 8'hC3, 1, 8'h3C};
    vecs[6] = '{1'b0, 1'b0, 11'h555, 8'h00, 2, 8'h5A};
    vecs[7] = '{1'b1, 1'b0, 11'h2AA, 8'h00, 2, 8'hC3};
    vecs[8] = '{1'b1, 1'b0, 11'h123, 8'h00, 2, 8'hA5};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_we = 1'b0; bus.vid_addr = '0; bus.vid_wdata = '0;

    // Reset state
    repeat (2) @(negedge phi0);
    check("rst_cs_b", {31'b0, bus.sram_CS_b}, 32'd1);
    check("rst_we_b", {31'b0, bus.sram_WE_b}, 32'd1);
    check("rst_oe_b", {31'b0, bus.sram_OE_b}, 32'd1);
    check("rst_a", {21'b0, bus.sram_A}, 32'd0);
    check("rst_din", {24'b0, bus.sram_Din}, 32'd0);
    check("rst_acks", {30'b0, bus.cpu_ack, bus.vid_ack}, 32'd0);
    check("rst_rdata", {16'b0, bus.cpu_rdata, bus.vid_rdata}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    rst_b = 1'b1;

    // CPU write 0x123 = 0xA5, pin-level timing
    @(negedge phi0);
    bus.cpu_we = 1'b1; bus.cpu_addr = 11'h123; bus.cpu_wdata = 8'hA5; bus.cpu_req = 1'b1;
    @(negedge phi0);
    check("wr_strobe_pins", {29'b0, bus.sram_CS_b, bus.sram_WE_b, bus.sram_OE_b}, 32'b001);
    check("wr_addr", {21'b0, bus.sram_A}, 32'h123);
    check("wr_din", {24'b0, bus.sram_Din}, 32'hA5);
    check("wr_busy", {31'b0, bus.busy}, 32'd1);
    check("wr_state", {30'b0, dbg_state}, 32'd1);
    check("wr_no_early_ack", {31'b0, bus.cpu_ack}, 32'd0);
    @(negedge phi0);
    check("wr_ack", {31'b0, bus.cpu_ack}, 32'd1);
    check("wr_strobes_off", {29'b0, bus.sram_CS_b, bus.sram_WE_b, bus.sram_OE_b}, 32'b111);
    check("wr_addr_hold", {21'b0, bus.sram_A}, 32'h123);
    check("wr_idle", {31'b0, bus.busy}, 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge phi0);
    check("wr_ack_one_cycle", {31'b0, bus.cpu_ack}, 32'd0);

    // CPU readback of 0x123
    bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    @(negedge phi0);
    check("rd_strobe_pins", {29'b0, bus.sram_CS_b, bus.sram_WE_b, bus.sram_OE_b}, 32'b010);
    @(negedge phi0);
    check("rd_capture_pins", {29'b0, bus.sram_CS_b, bus.sram_WE_b, bus.sram_OE_b}, 32'b111);
    check("rd_capture_state", {30'b0, dbg_state}, 32'd2);
    check("rd_no_early_ack", {31'b0, bus.cpu_ack}, 32'd0);
    @(negedge phi0);
    check("rd_ack", {31'b0, bus.cpu_ack}, 32'd1);
    check("rd_rdata", {24'b0, bus.cpu_rdata}, 32'hA5);
    bus.cpu_req = 1'b0;

    // Vector table of single-port accesses
    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].lat, 1'b0, vecs[i].rdata, $sformatf("vec%0d", i));
    end

    // Tie from reset: both read, held through ack; CPU wins first, then alternation
    @(negedge phi0);
    rst_b = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 11'h000; bus.cpu_req = 1'b1;
    bus.vid_we = 1'b0; bus.vid_addr = 11'h7FF; bus.vid_req = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h3C});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h3C});
    @(negedge phi0);
    rst_b = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge phi0);
      if (bus.cpu_ack || bus.vid_ack) begin
        e = exp_q.pop_front();
        check("tie_order", {31'b0, bus.vid_ack}, {31'b0, e[8]});
        check("tie_rdata", {24'b0, (bus.vid_ack ? bus.vid_rdata : bus.cpu_rdata)}, {24'b0, e[7:0]});
        got++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    check("tie_ack_count", got, 4);
    exp_q.delete();

    // Data isolation: vid writes while CPU keeps reading 0x000
    iso_acks = 0;
    fork
      begin
        bus.cpu_we = 1'b0; bus.cpu_addr = 11'h000; bus.cpu_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
          @(negedge phi0);
          if (bus.cpu_ack) begin
            check("iso_cpu_rdata", {24'b0, bus.cpu_rdata}, 32'h11);
            iso_acks++;
            if (c >= 18) break;
          end
        end
        bus.cpu_req = 1'b0;
      end
      begin
        repeat (4) @(negedge phi0);
        do_access(1'b1, 1'b1, 11'h7FF, 8'h3C, 3, 1'b1, 8'h3C, "iso_vid_wr");
      end
    join
    check("iso_cpu_progress", {31'b0, iso_acks >= 4}, 32'd1);

    // Reset during CAPTURE
    @(negedge phi0);
    bus.cpu_we = 1'b0; bus.cpu_addr = 11'h555; bus.cpu_req = 1'b1;
    @(negedge phi0);
    check("mid_strobe_state", {30'b0, dbg_state}, 32'd1);
    @(negedge phi0);
    check("mid_capture_state", {30'b0, dbg_state}, 32'd2);
    rst_b = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check("mid_rst_strobes", {29'b0, bus.sram_CS_b, bus.sram_WE_b, bus.sram_OE_b}, 32'b111);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_ack", {31'b0, bus.cpu_ack}, 32'd0);
    check("mid_rst_rdata", {24'b0, bus.cpu_rdata}, 32'd0);
    @(negedge phi0);
    rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge phi0);
      check("mid_rst_no_ack", {30'b0, bus.cpu_ack, bus.vid_ack}, 32'd0);
    end
    do_access(1'b0, 1'b0, 11'h555, 8'h00, 2, 1'b0, 8'h5A, "mid_rst_reread");

    // Back-to-back CPU writes, req re-raised the cycle after each ack
    #1;
    s0 = strobe_cnt;
    a0 = ack_cnt;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, 1'b1, ADDR_W'(i), DATA_W'(8'h80 + i), 1, 1'b0, 8'h5A, $sformatf("b2b_wr%0d", i));
    end
    repeat (3) @(negedge phi0);
    #1;
    check("b2b_strobes", strobe_cnt - s0, 4);
    check("b2b_acks", ack_cnt - a0, 4);
    do_access(1'b0, 1'b0, 11'h003, 8'h00, 2, 1'b0, 8'h83, "b2b_readback");
    do_access(1'b0, 1'b0, 11'h000, 8'h00, 2, 1'b0, 8'h80, "b2b_readback0");

    // Final report
    repeat (2) @(negedge phi0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
